// File: rtl/cpu16_pkg.sv
// Shared widths, shift op encodings and the buffered result entry for the 16-bit CPU execute stage.
// Optional macro SHIFT_CARRY_EN adds a carry-out bit to every entry.
package cpu16_pkg;

  localparam int unsigned DW = 16;
  localparam int unsigned SW = 4;
  localparam int unsigned TW = 3;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  typedef struct packed {
    logic [DW-1:0] result;
    logic [TW-1:0] rd;
`ifdef SHIFT_CARRY_EN
    logic          carry;
`endif
  } entry_t;

endpackage

// File: rtl/shift_core.sv
// Combinational 16-bit shifter: SLL/SRL/SRA/PASS.
// With SHIFT_CARRY_EN defined it also returns the last bit shifted out.
module shift_core
  import cpu16_pkg::*;
(
  input  logic [1:0]    op_i,
  input  logic [DW-1:0] a_i,
  input  logic [SW-1:0] shamt_i,
`ifdef SHIFT_CARRY_EN
  output logic          carry_o,
`endif
  output logic [DW-1:0] result_o
);

  always_comb begin
    result_o = a_i;
    case (op_i)
      OP_SLL:  result_o = a_i << shamt_i;
      OP_SRL:  result_o = a_i >> shamt_i;
      OP_SRA:  result_o = DW'($signed(a_i) >>> shamt_i);
      default: result_o = a_i;
    endcase
  end

`ifdef SHIFT_CARRY_EN
  logic [SW-1:0] sll_idx;
  logic [SW-1:0] srl_idx;

  // Indices only matter for shamt != 0, where they stay inside the operand.
  always_comb begin
    sll_idx = SW'(0) - shamt_i;
    srl_idx = shamt_i - SW'(1);
    carry_o = 1'b0;
    if (shamt_i != SW'(0)) begin
      case (op_i)
        OP_SLL:  carry_o = a_i[sll_idx];
        OP_SRL:  carry_o = a_i[srl_idx];
        OP_SRA:  carry_o = a_i[srl_idx];
        default: carry_o = 1'b0;
      endcase
    end
  end
`endif

endmodule

// File: rtl/shift_ex_stage.sv
// Execute-stage shift unit with a 2-entry elastic buffer (main R + skid S) toward writeback.
// Optional macro SHIFT_CARRY_EN adds the out_carry port.
module shift_ex_stage
  import cpu16_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_op,
  input  logic [DW-1:0] in_a,
  input  logic [SW-1:0] in_shamt,
  input  logic [TW-1:0] in_rd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_result,
`ifdef SHIFT_CARRY_EN
  output logic          out_carry,
`endif
  output logic [TW-1:0] out_rd
);

  entry_t        r_q, r_d, s_q, s_d, new_c;
  logic          r_valid_q, r_valid_d, s_valid_q, s_valid_d;
  logic          accept_c, transfer_c;
  logic [DW-1:0] core_result;
`ifdef SHIFT_CARRY_EN
  logic          core_carry;
`endif

  shift_core u_core (
    .op_i     (in_op),
    .a_i      (in_a),
    .shamt_i  (in_shamt),
`ifdef SHIFT_CARRY_EN
    .carry_o  (core_carry),
`endif
    .result_o (core_result)
  );

  // Results are computed on acceptance; only finished entries are stored.
  always_comb begin
    new_c        = '0;
    new_c.result = core_result;
    new_c.rd     = in_rd;
`ifdef SHIFT_CARRY_EN
    new_c.carry  = core_carry;
`endif
  end

  assign accept_c   = in_valid && !s_valid_q;
  assign transfer_c = r_valid_q && out_ready;

  always_comb begin
    r_d       = r_q;
    s_d       = s_q;
    r_valid_d = r_valid_q;
    s_valid_d = s_valid_q;
    if (!r_valid_q || transfer_c) begin
      if (s_valid_q) begin
        r_d       = s_q;
        r_valid_d = 1'b1;
        s_valid_d = accept_c;
        if (accept_c) s_d = new_c;
      end else if (accept_c) begin
        r_d       = new_c;
        r_valid_d = 1'b1;
      end else begin
        r_valid_d = 1'b0;
      end
    end else if (accept_c) begin
      s_d       = new_c;
      s_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q       <= '0;
      s_q       <= '0;
      r_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
    end else begin
      r_q       <= r_d;
      s_q       <= s_d;
      r_valid_q <= r_valid_d;
      s_valid_q <= s_valid_d;
    end
  end

  // in_ready comes straight from state, never from out_ready.
  assign in_ready   = !s_valid_q;
  assign out_valid  = r_valid_q;
  assign out_result = r_q.result;
  assign out_rd     = r_q.rd;
`ifdef SHIFT_CARRY_EN
  assign out_carry  = r_q.carry;
`endif

endmodule

// File: tb/tb_shift_ex_stage.sv
// Self-checking bench for shift_ex_stage: directed test-plan vectors plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_shift_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [15:0] in_a;
  logic [3:0]  in_shamt;
  logic [2:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [2:0]  out_rd;
`ifdef SHIFT_CARRY_EN
  logic        out_carry;
`endif

  shift_ex_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_shamt   (in_shamt),
    .in_rd      (in_rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
`ifdef SHIFT_CARRY_EN
    .out_carry  (out_carry),
`endif
    .out_rd     (out_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    int result;
    int rd;
    int carry;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   chk_en   = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: shifts expressed as multiply/divide by powers of two on plain integers.
  function automatic exp_t model(input int op, input int a, input int sh, input int rd);
    exp_t e;
    int p, sv;
    p = 1 << sh;
    case (op)
      0: e.result = (a * p) % 65536;
      1: e.result = a / p;
      2: begin
        sv = (a >= 32768) ? a - 65536 : a;
        e.result = (sv >= 0) ? sv / p : -((-sv + p - 1) / p);
        if (e.result < 0) e.result += 65536;
      end
      default: e.result = a;
    endcase
    e.rd = rd;
    if (sh == 0 || op == 3) e.carry = 0;
    else if (op == 0) e.carry = (a / (1 << (16 - sh))) % 2;
    else e.carry = (a / (p / 2)) % 2;
    return e;
  endfunction

  // Model update on the same edge the DUT samples its inputs.
  always @(posedge clk) begin : mdl
    bit acc, xfer;
    if (rst) begin
      q.delete();
    end else begin
      acc  = in_valid && (q.size() < 2);
      xfer = (q.size() > 0) && out_ready;
      if (xfer) void'(q.pop_front());
      if (acc) q.push_back(model(int'(in_op), int'(in_a), int'(in_shamt), int'(in_rd)));
    end
  end

  // Per-cycle compare against the model, mid-cycle.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("cmp_out_valid", 32'(out_valid), 32'(q.size() > 0));
      check("cmp_in_ready", 32'(in_ready), 32'(q.size() < 2));
      if (q.size() > 0) begin
        check("cmp_out_result", 32'(out_result), 32'(q[0].result));
        check("cmp_out_rd", 32'(out_rd), 32'(q[0].rd));
`ifdef SHIFT_CARRY_EN
        check("cmp_out_carry", 32'(out_carry), 32'(q[0].carry));
`endif
      end
    end
  end

  // Present inputs now (2 time units after an edge), then advance past the next edge.
  task automatic cyc(input logic r, input logic v, input logic [1:0] op, input logic [15:0] a,
                     input logic [3:0] sh, input logic [2:0] rd, input logic ordy);
    rst = r; in_valid = v; in_op = op; in_a = a; in_shamt = sh; in_rd = rd; out_ready = ordy;
    @(posedge clk);
    #2;
  endtask

  exp_t m;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_a = 16'h0; in_shamt = 4'h0;
    in_rd = 3'h0; out_ready = 1'b0;

    // Pin the reference model with hand-computed values.
    m = model(2, 32'h8000, 15, 0); check("model_sra", 32'(m.result), 32'hFFFF);
    m = model(2, 32'h7F00, 4, 0);  check("model_sra_pos", 32'(m.result), 32'h07F0);
    m = model(0, 32'h8001, 1, 0);  check("model_sll_carry", 32'(m.carry), 32'h1);
    m = model(1, 32'h0002, 2, 0);  check("model_srl_carry", 32'(m.carry), 32'h1);

    @(posedge clk); #2;
    cyc(1'b1, 1'b0, 2'd0, 16'h0, 4'd0, 3'd0, 1'b0);
    chk_en = 1'b1;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_out_result", 32'(out_result), 32'h0);
    check("rst_out_rd", 32'(out_rd), 32'h0);
`ifdef SHIFT_CARRY_EN
    check("rst_out_carry", 32'(out_carry), 32'h0);
`endif

    // Directed arithmetic, one-cycle latency.
    cyc(1'b0, 1'b1, 2'd0, 16'h0005, 4'd4, 3'd0, 1'b1);
    check("sll4_valid", 32'(out_valid), 32'h1);
    check("sll4_result", 32'(out_result), 32'h0050);
    cyc(1'b0, 1'b1, 2'd0, 16'h0005, 4'd2, 3'd3, 1'b1);
    check("sll2_result", 32'(out_result), 32'h0014);
    check("sll2_rd", 32'(out_rd), 32'h3);
    cyc(1'b0, 1'b1, 2'd2, 16'h8000, 4'd15, 3'd1, 1'b1);
    check("sra15_result", 32'(out_result), 32'hFFFF);
    cyc(1'b0, 1'b1, 2'd1, 16'h8000, 4'd15, 3'd2, 1'b1);
    check("srl15_result", 32'(out_result), 32'h0001);
    cyc(1'b0, 1'b1, 2'd3, 16'h1234, 4'd7, 3'd4, 1'b1);
    check("pass_result", 32'(out_result), 32'h1234);
`ifdef SHIFT_CARRY_EN
    cyc(1'b0, 1'b1, 2'd0, 16'h8001, 4'd1, 3'd5, 1'b1);
    check("c_sll_result", 32'(out_result), 32'h0002);
    check("c_sll_carry", 32'(out_carry), 32'h1);
    cyc(1'b0, 1'b1, 2'd1, 16'h0002, 4'd2, 3'd6, 1'b1);
    check("c_srl_result", 32'(out_result), 32'h0000);
    check("c_srl_carry", 32'(out_carry), 32'h1);
    cyc(1'b0, 1'b1, 2'd1, 16'hFFFF, 4'd0, 3'd7, 1'b1);
    check("c_sh0_carry", 32'(out_carry), 32'h0);
`endif
    cyc(1'b0, 1'b0, 2'd0, 16'h0, 4'd0, 3'd0, 1'b1);
    check("idle_out_valid", 32'(out_valid), 32'h0);

    // Backpressure: three back-to-back ops, only two fit.
    cyc(1'b0, 1'b1, 2'd0, 16'h0001, 4'd1, 3'd1, 1'b0);
    check("bp1_in_ready", 32'(in_ready), 32'h1);
    check("bp1_result", 32'(out_result), 32'h0002);
    cyc(1'b0, 1'b1, 2'd0, 16'h0001, 4'd2, 3'd2, 1'b0);
    check("bp2_in_ready", 32'(in_ready), 32'h0);
    check("bp2_result_held", 32'(out_result), 32'h0002);
    cyc(1'b0, 1'b1, 2'd0, 16'h0001, 4'd3, 3'd3, 1'b0);
    check("bp3_in_ready", 32'(in_ready), 32'h0);
    check("bp3_rd_held", 32'(out_rd), 32'h1);
    cyc(1'b0, 1'b1, 2'd0, 16'h0001, 4'd3, 3'd3, 1'b1);
    check("drain1_result", 32'(out_result), 32'h0004);
    check("drain1_in_ready", 32'(in_ready), 32'h1);
    cyc(1'b0, 1'b1, 2'd0, 16'h0001, 4'd3, 3'd3, 1'b1);
    check("drain2_result", 32'(out_result), 32'h0008);
    check("drain2_rd", 32'(out_rd), 32'h3);
    cyc(1'b0, 1'b0, 2'd0, 16'h0, 4'd0, 3'd0, 1'b1);
    check("drain_empty", 32'(out_valid), 32'h0);

    // Reset with two entries buffered and an accept attempt in the reset cycle.
    cyc(1'b0, 1'b1, 2'd3, 16'hAAAA, 4'd0, 3'd1, 1'b0);
    cyc(1'b0, 1'b1, 2'd3, 16'hBBBB, 4'd0, 3'd2, 1'b0);
    cyc(1'b1, 1'b1, 2'd3, 16'hCCCC, 4'd0, 3'd3, 1'b0);
    check("mrst_out_valid", 32'(out_valid), 32'h0);
    check("mrst_in_ready", 32'(in_ready), 32'h1);
    cyc(1'b0, 1'b1, 2'd1, 16'h00F0, 4'd4, 3'd5, 1'b1);
    check("post_rst_valid", 32'(out_valid), 32'h1);
    check("post_rst_result", 32'(out_result), 32'h000F);
    check("post_rst_rd", 32'(out_rd), 32'h5);

    // Randomized traffic; the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) == 0),
          ($urandom_range(0, 3) != 0),
          2'($urandom_range(0, 3)),
          16'($urandom),
          4'($urandom_range(0, 15)),
          3'($urandom_range(0, 7)),
          (i >= 1500) ? 1'b1 : ($urandom_range(0, 2) != 0));
    end
    cyc(1'b0, 1'b0, 2'd0, 16'h0, 4'd0, 3'd0, 1'b1);
    cyc(1'b0, 1'b0, 2'd0, 16'h0, 4'd0, 3'd0, 1'b1);
    cyc(1'b0, 1'b0, 2'd0, 16'h0, 4'd0, 3'd0, 1'b1);
    check("final_empty", 32'(out_valid), 32'h0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
